// File: rtl/vec_mem_responder.sv
// vec_mem_responder: turns one vector load/store request into NUM_ELEM
// sequential scalar accesses on a single-port RAM, then returns the assembled
// vector (load) or a completion (store) on a valid/ready response channel.
// Optional feature macro: VEC_MEM_STRIDE_EN adds req_stride (element k is at
// base + k*stride); without it the stride is fixed at 1.
module vec_mem_responder #(
    parameter int ELEM_W   = 16,
    parameter int NUM_ELEM = 16,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
`ifdef VEC_MEM_STRIDE_EN
    input  logic [ADDR_W-1:0]            req_stride,
`endif
    input  logic [NUM_ELEM*ELEM_W-1:0]   req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_write,
    output logic [NUM_ELEM*ELEM_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [ELEM_W-1:0]            ram_wdata,
    output logic                         ram_wren,
    input  logic [ELEM_W-1:0]            ram_q,
    output logic                         busy
);

    localparam int CNT_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEM - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                           state, state_nxt;
    logic                             wr_q;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]  wdata_q;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]  acc;
    logic [CNT_W-1:0]                 cnt;
    logic [RD_LAT-1:0]                rd_vld;
    logic [RD_LAT-1:0][CNT_W-1:0]     rd_idx;
    logic [ADDR_W-1:0]                stride_q;

    logic accept, issue_last, cap, cap_last;

    assign accept     = req_valid && req_ready;
    assign issue_last = (state == ISSUE) && (cnt == LAST);
    // The oldest stage of the read tracker lines up with valid ram_q.
    assign cap        = rd_vld[RD_LAT-1];
    assign cap_last   = cap && (rd_idx[RD_LAT-1] == LAST);

`ifdef VEC_MEM_STRIDE_EN
    // Stride is latched with the rest of the request so it cannot change mid-op.
    always_ff @(posedge clk) begin
        if (rst)         stride_q <= '0;
        else if (accept) stride_q <= req_stride;
    end
`else
    assign stride_q = ADDR_W'(1);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: stores skip DRAIN since nothing is outstanding.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = ISSUE;
            ISSUE:   if (issue_last) state_nxt = wr_q ? RESP : DRAIN;
            DRAIN:   if (cap_last)   state_nxt = RESP;
            RESP:    if (rsp_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Request latch, RAM address/data sequencing, read tracking and capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            acc       <= '0;
            cnt       <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            rd_vld    <= '0;
            rd_idx    <= '0;
        end else begin
            if (accept) begin
                // Element 0 goes out in the cycle right after the accept.
                wr_q      <= req_write;
                wdata_q   <= req_wdata;
                acc       <= '0;
                cnt       <= '0;
                ram_addr  <= req_addr;
                ram_wdata <= req_wdata[ELEM_W-1:0];
                ram_wren  <= req_write;
            end else if (issue_last) begin
                ram_wren  <= 1'b0;
            end else if (state == ISSUE) begin
                cnt       <= cnt + CNT_W'(1);
                ram_addr  <= ram_addr + stride_q;
                ram_wdata <= wdata_q[cnt + CNT_W'(1)];
            end

            for (int i = RD_LAT - 1; i > 0; i--) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_idx[i] <= rd_idx[i-1];
            end
            rd_vld[0] <= (state == ISSUE) && !wr_q;
            rd_idx[0] <= cnt;

            if (cap) acc[rd_idx[RD_LAT-1]] <= ram_q;
        end
    end

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign rsp_write = (state == RESP) && wr_q;
    assign rsp_rdata = acc;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder with a behavioural 1-cycle RAM.
// Inputs change around the falling edge; outputs are checked 1 time unit later.
module tb_vec_mem_responder;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int AW = 19;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready, req_write;
    logic [AW-1:0]   req_addr;
    logic [N*W-1:0]  req_wdata;
    logic            rsp_valid, rsp_ready, rsp_write;
    logic [N*W-1:0]  rsp_rdata;
    logic [AW-1:0]   ram_addr;
    logic [W-1:0]    ram_wdata, ram_q;
    logic            ram_wren, busy;
`ifdef VEC_MEM_STRIDE_EN
    logic [AW-1:0]   req_stride;
`endif

    logic            pl_we;
    logic [AW-1:0]   pl_addr;
    logic [W-1:0]    pl_data;
    logic [W-1:0]    mem [0:(1<<AW)-1];
    int              wr_cnt = 0;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    vec_mem_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr),
`ifdef VEC_MEM_STRIDE_EN
        .req_stride(req_stride),
`endif
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy)
    );

    // Single-port RAM, read latency 1, with a backdoor preload port.
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Presents a request for one edge; returns at the cycle-0 falling edge.
    task automatic issue_req(input logic wr, input logic [AW-1:0] a, input logic [N*W-1:0] wd);
        req_write = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        #1 chk("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        // Scramble the inputs: latched fields must not follow them.
        req_valid = 1'b0; req_addr = 19'h1234; req_wdata = '1; req_write = ~wr;
    endtask

    // Checks ISSUE cycles 0..n-1; returns 1 unit after cycle n-1's falling edge.
    task automatic check_issue(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                               input logic [N*W-1:0] wd, input int n);
        logic [AW-1:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + AW'(k) * stride;
            #1;
            chk("issue_addr", ram_addr, a);
            chk("issue_wren", ram_wren, wr);
            if (wr) chk("issue_wdata", ram_wdata, wd[k*W +: W]);
            chk("issue_busy", busy, 1'b1);
            chk("issue_no_rsp", rsp_valid, 1'b0);
            if (k != n - 1) @(negedge clk);
        end
    endtask

    // Called at cycle 16's falling edge; checks response timing and payload.
    task automatic finish_rsp(input logic wr, input logic [N*W-1:0] exp);
        if (!wr) begin
            #1 chk("drain_no_rsp", rsp_valid, 1'b0);
            chk("drain_wren", ram_wren, 1'b0);
            @(negedge clk);
        end
        #1;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_write", rsp_write, wr);
        chk("rsp_rdata", rsp_rdata, exp);
        chk("rsp_req_ready", req_ready, 1'b0);
        chk("rsp_wren", ram_wren, 1'b0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_req_ready", req_ready, 1'b1);
        chk("post_busy", busy, 1'b0);
    endtask

    initial begin
        logic [N*W-1:0] ev, wd;
        int w0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
`ifdef VEC_MEM_STRIDE_EN
        req_stride = 19'd1;
`endif

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_write", rsp_write, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_wren", ram_wren, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1 chk("ready_after_rst", req_ready, 1'b1);

        // RAM contents.
        for (int k = 0; k < N; k++) preload(AW'(100 + k), W'(k * 3));
        preload(19'h7FFFE, 16'h1111);
        preload(19'h7FFFF, 16'h2222);
        for (int k = 0; k < 14; k++) preload(AW'(k), 16'h3000 + W'(k));
        for (int k = 0; k < N; k++) preload(19'h300 + AW'(k), 16'hDEAD);

        // Load from 100.
        for (int k = 0; k < N; k++) ev[k*W +: W] = W'(k * 3);
        issue_req(1'b0, 19'd100, '0);
        check_issue(1'b0, 19'd100, 19'd1, '0, N);
        @(negedge clk);
        finish_rsp(1'b0, ev);
        handshake();

        // Store to 0x200.
        for (int k = 0; k < N; k++) wd[k*W +: W] = 16'hA000 + W'(k);
        w0 = wr_cnt;
        issue_req(1'b1, 19'h200, wd);
        check_issue(1'b1, 19'h200, 19'd1, wd, N);
        @(negedge clk);
        finish_rsp(1'b1, '0);
        chk("store_write_count", wr_cnt - w0, 16);
        handshake();

        // Read the stored vector back.
        issue_req(1'b0, 19'h200, '0);
        check_issue(1'b0, 19'h200, 19'd1, '0, N);
        @(negedge clk);
        finish_rsp(1'b0, wd);
        handshake();

        // Address wrap, then hold the response under backpressure.
        ev[0 +: W] = 16'h1111;
        ev[W +: W] = 16'h2222;
        for (int k = 2; k < N; k++) ev[k*W +: W] = 16'h3000 + W'(k - 2);
        issue_req(1'b0, 19'h7FFFE, '0);
        check_issue(1'b0, 19'h7FFFE, 19'd1, '0, N);
        @(negedge clk);
        finish_rsp(1'b0, ev);
        w0 = wr_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = ~req_valid; req_write = c[0]; req_addr = AW'($urandom);
            #1;
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_rdata", rsp_rdata, ev);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_wren", ram_wren, 1'b0);
            chk("bp_addr_hold", ram_addr, 19'h0000D);
        end
        req_valid = 1'b0;
        chk("bp_no_writes", wr_cnt - w0, 0);
        handshake();

        // Reset in ISSUE cycle 5 of a store to 0x300.
        for (int k = 0; k < N; k++) wd[k*W +: W] = 16'hB000 + W'(k);
        w0 = wr_cnt;
        issue_req(1'b1, 19'h300, wd);
        check_issue(1'b1, 19'h300, 19'd1, wd, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_wren", ram_wren, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rsp", rsp_valid, 1'b0);
        chk("mid_rst_addr", ram_addr, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1 chk("mid_rst_quiet", rsp_valid | busy | ram_wren, 1'b0);
        end
        chk("mid_rst_writes", wr_cnt - w0, 6);
        for (int k = 0; k < N; k++) ev[k*W +: W] = (k < 6) ? 16'hB000 + W'(k) : 16'hDEAD;
        @(negedge clk);
        issue_req(1'b0, 19'h300, '0);
        check_issue(1'b0, 19'h300, 19'd1, '0, N);
        @(negedge clk);
        finish_rsp(1'b0, ev);
        handshake();

`ifdef VEC_MEM_STRIDE_EN
        // Strided load, then a zero-stride load replicating one word.
        for (int k = 0; k < N; k++) preload(19'd10 + AW'(4 * k), 16'h4000 + W'(k));
        for (int k = 0; k < N; k++) ev[k*W +: W] = 16'h4000 + W'(k);
        req_stride = 19'd4;
        issue_req(1'b0, 19'd10, '0);
        check_issue(1'b0, 19'd10, 19'd4, '0, N);
        @(negedge clk);
        finish_rsp(1'b0, ev);
        handshake();
        for (int k = 0; k < N; k++) ev[k*W +: W] = 16'h4000;
        req_stride = 19'd0;
        issue_req(1'b0, 19'd10, '0);
        check_issue(1'b0, 19'd10, 19'd0, '0, N);
        @(negedge clk);
        finish_rsp(1'b0, ev);
        handshake();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
